// File: rtl/multi_cycle_machine_if.sv
// rtl/multi_cycle_machine_if.sv - memory request/response bundle for the multi-cycle core
interface multi_cycle_machine_if;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        mem_ready;

    modport master (
        output mem_req, mem_we, mem_addr, mem_wdata,
        input  mem_rdata, mem_ready
    );

    modport slave (
        input  mem_req, mem_we, mem_addr, mem_wdata,
        output mem_rdata, mem_ready
    );
endinterface

// File: rtl/multi_cycle_machine.sv
// rtl/multi_cycle_machine.sv - MIPS-subset multi-cycle core with a single shared memory port
module multi_cycle_machine #(
    parameter logic [31:0] RESET_PC  = 32'h0040_0000,
    parameter logic [4:0]  LINK_REG  = 5'd31,
    parameter int          REG_COUNT = 32
) (
    input  logic                         clk,
    input  logic                         reset,
    multi_cycle_machine_if.master        mem,
    output logic [31:0]                  pc,
    output logic                         retired,
    output logic                         halted
);
    localparam int RW = $clog2(REG_COUNT);

    typedef enum logic [2:0] {FETCH, DECODE, EXEC, MEM, WB, HALT} state_t;

    localparam logic [5:0] OP_R = 6'h00, OP_J = 6'h02, OP_JAL = 6'h03, OP_BEQ = 6'h04,
                           OP_BNE = 6'h05, OP_ADDI = 6'h08, OP_LW = 6'h23, OP_SW = 6'h2B;
    localparam logic [5:0] F_JR = 6'h08, F_JALR = 6'h09, F_ADD = 6'h20, F_SUB = 6'h22,
                           F_AND = 6'h24, F_OR = 6'h25, F_SLT = 6'h2A;

    state_t        state;
    logic [31:0]   ir, a, b, res;
    logic [31:0]   regs [REG_COUNT];

    logic [5:0]    op, funct;
    logic [RW-1:0] rs, rt, rd, link, wb_dst;
    logic [31:0]   simm, pc4, sum, alu_out, exec_npc;
    logic          is_r_alu, legal;
    logic          unused_bits;

    assign op          = ir[31:26];
    assign funct       = ir[5:0];
    assign rs          = ir[21 +: RW];
    assign rt          = ir[16 +: RW];
    assign rd          = ir[11 +: RW];
    assign link        = LINK_REG[RW-1:0];
    assign wb_dst      = (op == OP_R) ? rd : rt;
    assign simm        = {{16{ir[15]}}, ir[15:0]};
    assign pc4         = pc + 32'd4;
    assign sum         = a + simm;
    assign unused_bits = ^{ir[10:6], sum[1:0]};

    always_comb begin
        is_r_alu = (op == OP_R) && (funct inside {F_ADD, F_SUB, F_AND, F_OR, F_SLT});
        legal    = is_r_alu
                || ((op == OP_R) && (funct inside {F_JR, F_JALR}))
                || (op inside {OP_J, OP_JAL, OP_BEQ, OP_BNE, OP_ADDI, OP_LW, OP_SW});
    end

    always_comb begin
        alu_out = sum;
        if (op == OP_R) begin
            case (funct)
                F_ADD:   alu_out = a + b;
                F_SUB:   alu_out = a - b;
                F_AND:   alu_out = a & b;
                F_OR:    alu_out = a | b;
                F_SLT:   alu_out = {31'd0, $signed(a) < $signed(b)};
                default: alu_out = '0;
            endcase
        end
    end

    // Only control-flow instructions use this; R-type here means jr/jalr.
    always_comb begin
        exec_npc = pc4;
        if ((op == OP_BEQ && a == b) || (op == OP_BNE && a != b))
            exec_npc = pc4 + {simm[29:0], 2'b00};
        else if (op == OP_J || op == OP_JAL)
            exec_npc = {pc4[31:28], ir[25:0], 2'b00};
        else if (op == OP_R)
            exec_npc = {a[31:2], 2'b00};
    end

    always_ff @(posedge clk) begin
        retired <= 1'b0;
        if (!reset) begin
            state         <= FETCH;
            pc            <= RESET_PC;
            ir            <= '0;
            a             <= '0;
            b             <= '0;
            res           <= '0;
            halted        <= 1'b0;
            mem.mem_req   <= 1'b0;
            mem.mem_we    <= 1'b0;
            mem.mem_addr  <= {RESET_PC[31:2], 2'b00};
            mem.mem_wdata <= '0;
            for (int i = 0; i < REG_COUNT; i++) regs[i] <= '0;
        end else begin
            case (state)
                // mem_req is only low in FETCH for the first cycle after reset.
                FETCH: begin
                    if (!mem.mem_req) begin
                        mem.mem_req  <= 1'b1;
                        mem.mem_we   <= 1'b0;
                        mem.mem_addr <= {pc[31:2], 2'b00};
                    end else if (mem.mem_ready) begin
                        ir          <= mem.mem_rdata;
                        mem.mem_req <= 1'b0;
                        state       <= DECODE;
                    end
                end
                DECODE: begin
                    a <= regs[rs];
                    b <= regs[rt];
                    if (legal) begin
                        state <= EXEC;
                    end else begin
                        state  <= HALT;
                        halted <= 1'b1;
                    end
                end
                EXEC: begin
                    if (is_r_alu || op == OP_ADDI) begin
                        res   <= alu_out;
                        state <= WB;
                    end else if (op == OP_LW || op == OP_SW) begin
                        mem.mem_req   <= 1'b1;
                        mem.mem_we    <= (op == OP_SW);
                        mem.mem_addr  <= {sum[31:2], 2'b00};
                        mem.mem_wdata <= b;
                        state         <= MEM;
                    end else begin
                        if (op == OP_JAL && link != '0) regs[link] <= pc4;
                        if (op == OP_R && funct == F_JALR && rd != '0) regs[rd] <= pc4;
                        retired      <= 1'b1;
                        pc           <= exec_npc;
                        mem.mem_req  <= 1'b1;
                        mem.mem_we   <= 1'b0;
                        mem.mem_addr <= {exec_npc[31:2], 2'b00};
                        state        <= FETCH;
                    end
                end
                MEM: begin
                    if (mem.mem_ready) begin
                        mem.mem_we <= 1'b0;
                        if (op == OP_SW) begin
                            retired      <= 1'b1;
                            pc           <= pc4;
                            mem.mem_req  <= 1'b1;
                            mem.mem_addr <= {pc4[31:2], 2'b00};
                            state        <= FETCH;
                        end else begin
                            res         <= mem.mem_rdata;
                            mem.mem_req <= 1'b0;
                            state       <= WB;
                        end
                    end
                end
                WB: begin
                    if (wb_dst != '0) regs[wb_dst] <= res;
                    retired      <= 1'b1;
                    pc           <= pc4;
                    mem.mem_req  <= 1'b1;
                    mem.mem_we   <= 1'b0;
                    mem.mem_addr <= {pc4[31:2], 2'b00};
                    state        <= FETCH;
                end
                HALT:    state <= HALT;
                default: state <= HALT;
            endcase
        end
    end
endmodule
